// File: rtl/soc_pkg.sv
// soc_pkg: shared SOC bus types, timebase constants and bus-arbiter states
package soc_pkg;
  typedef logic [31:0] soc_addr_t;
  typedef logic [3:0]  soc_we_t;
  typedef logic [31:0] soc_data_t;
  typedef logic [6:0]  cnt_1us_t;
  localparam cnt_1us_t NUM_1US_CLKS = 7'd64;
  localparam soc_data_t SOC_ERR_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACTIVE,
    ARB_RESP
  } arb_state_t;
endpackage

// File: rtl/soc_timebase.sv
// soc_timebase: 1 us prescaler counting 0..NUM_1US_CLKS with sync clear and wrap tick
module soc_timebase
  import soc_pkg::*;
(
  input  logic     clk,
  input  logic     arst_n,
  input  logic     clr,
  output cnt_1us_t cnt,
  output logic     tick
);
  assign tick = cnt == NUM_1US_CLKS;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + cnt_1us_t'(1);
  end
endmodule

// File: rtl/soc_bus_arb.sv
// soc_bus_arb: two-master round-robin arbiter onto one slave bus with microsecond response timeout
module soc_bus_arb
  import soc_pkg::*;
#(
  parameter int TIMEOUT_US = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [1:0]           m_vld,
  input  soc_addr_t [1:0]      m_addr,
  input  soc_we_t [1:0]        m_we,
  input  soc_data_t [1:0]      m_wdat,
  output logic [1:0]           m_rdy,
  output logic [1:0]           m_err,
  output soc_data_t            m_rdat,
  output logic                 s_vld,
  output soc_addr_t            s_addr,
  output soc_we_t              s_we,
  output soc_data_t            s_wdat,
  input  logic                 s_rdy,
  input  soc_data_t            s_rdat,
  output logic [1:0]           gnt
);
  arb_state_t state, state_nxt;
  cnt_1us_t   pre_cnt;
  logic       tick, start, win, last, done, timeout, err_q;
  logic [7:0] us_cnt;
  assign start = state == ARB_IDLE && |m_vld;
  // on a tie the master not granted last wins, otherwise the sole requester
  assign win = &m_vld ? ~last : m_vld[1];
  // ACTIVE cycle TIMEOUT_US*65 is the one where the final prescaler wrap lands
  assign timeout = tick && us_cnt == 8'(TIMEOUT_US - 1);
  assign done = state == ARB_ACTIVE && (s_rdy || timeout);
  assign m_rdy = state == ARB_RESP ? gnt : 2'b00;
  assign m_err = state == ARB_RESP && err_q ? gnt : 2'b00;
  soc_timebase u_tb (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (start),
    .cnt   (pre_cnt),
    .tick  (tick)
  );
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ARB_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == ARB_IDLE   ? (start ? ARB_ACTIVE : ARB_IDLE) :
                state == ARB_ACTIVE ? (done ? ARB_RESP : ARB_ACTIVE) : ARB_IDLE;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) us_cnt <= '0;
    else if (start) us_cnt <= '0;
    else if (tick) us_cnt <= us_cnt + 8'd1;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s_vld  <= 1'b0;
      s_addr <= '0;
      s_we   <= '0;
      s_wdat <= '0;
      m_rdat <= '0;
      err_q  <= 1'b0;
      gnt    <= 2'b00;
      last   <= 1'b1;
    end else begin
      if (start) begin
        s_vld  <= 1'b1;
        s_addr <= m_addr[win];
        s_we   <= m_we[win];
        s_wdat <= m_wdat[win];
        gnt    <= win ? 2'b10 : 2'b01;
        last   <= win;
      end
      if (done) begin
        s_vld  <= 1'b0;
        m_rdat <= s_rdy ? s_rdat : SOC_ERR_DATA;
        err_q  <= !s_rdy;
      end
      if (state == ARB_RESP) gnt <= 2'b00;
    end
  end
  logic unused_ok;
  assign unused_ok = ^pre_cnt;
endmodule

// File: tb/tb_soc_bus_arb.sv
// tb_soc_bus_arb: directed checks of arbitration, latency, timeout, race and async reset
module tb_soc_bus_arb;
  import soc_pkg::*;
  logic            clk, arst_n, s_vld, s_rdy;
  logic [1:0]      m_vld, m_rdy, m_err, gnt;
  soc_addr_t [1:0] m_addr;
  soc_we_t [1:0]   m_we;
  soc_data_t [1:0] m_wdat;
  soc_data_t       m_rdat, s_wdat, s_rdat;
  soc_addr_t       s_addr;
  soc_we_t         s_we;
  int              n_chk = 0, n_err = 0;
  logic            early;

  soc_bus_arb #(.TIMEOUT_US(2)) dut (
    .clk(clk), .arst_n(arst_n), .m_vld(m_vld), .m_addr(m_addr), .m_we(m_we),
    .m_wdat(m_wdat), .m_rdy(m_rdy), .m_err(m_err), .m_rdat(m_rdat), .s_vld(s_vld),
    .s_addr(s_addr), .s_we(s_we), .s_wdat(s_wdat), .s_rdy(s_rdy), .s_rdat(s_rdat),
    .gnt(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    arst_n = 1'b0; m_vld = 2'b00; s_rdy = 1'b0; s_rdat = '0;
    m_addr = '0; m_we = '0; m_wdat = '0;
    #12;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_svld", 32'(s_vld), 0);
    chk("rst_mrdy", 32'(m_rdy), 0);
    chk("rst_merr", 32'(m_err), 0);
    chk("rst_rdat", m_rdat, 0);
    chk("rst_saddr", s_addr, 0);
    arst_n = 1'b1;
    step();
    // contention, immediate slave: order 0,1,0,1
    m_addr[0] = 32'h200; m_addr[1] = 32'h300; m_vld = 2'b11; s_rdy = 1'b1; s_rdat = 32'h5555_0000;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ct_gnt", 32'(gnt), i[0] ? 32'd2 : 32'd1);
      chk("ct_saddr", s_addr, i[0] ? 32'h300 : 32'h200);
      step();
      chk("ct_mrdy", 32'(m_rdy), i[0] ? 32'd2 : 32'd1);
      if (i == 3) m_vld = 2'b00;
      step();
      chk("ct_idle", 32'(gnt), 0);
    end
    s_rdy = 1'b0;
    // single read by master 0, slave answers in second ACTIVE cycle
    m_vld = 2'b01; m_addr[0] = 32'h100; m_we[0] = 4'h0;
    step();
    chk("rd_svld", 32'(s_vld), 1);
    chk("rd_saddr", s_addr, 32'h100);
    chk("rd_swe", 32'(s_we), 0);
    chk("rd_gnt", 32'(gnt), 1);
    m_vld = 2'b00;
    step();
    chk("rd_hold", 32'(s_vld), 1);
    s_rdy = 1'b1; s_rdat = 32'h1234_5678;
    step();
    s_rdy = 1'b0;
    chk("rd_mrdy", 32'(m_rdy), 1);
    chk("rd_rdat", m_rdat, 32'h1234_5678);
    chk("rd_merr", 32'(m_err), 0);
    chk("rd_svld0", 32'(s_vld), 0);
    step();
    chk("rd_pulse", 32'(m_rdy), 0);
    chk("rd_gnt0", 32'(gnt), 0);
    // write by master 1; payload changes must not reach the slave bus
    m_vld = 2'b10; m_addr[1] = 32'h40; m_we[1] = 4'b0101; m_wdat[1] = 32'hAABB_CCDD;
    step();
    chk("wr_gnt", 32'(gnt), 2);
    chk("wr_swe", 32'(s_we), 32'h5);
    chk("wr_wdat", s_wdat, 32'hAABB_CCDD);
    m_vld = 2'b00; m_we[1] = 4'hF; m_wdat[1] = 32'h0; m_addr[1] = 32'h99;
    step(); step(); step();
    chk("wr_hold_we", 32'(s_we), 32'h5);
    chk("wr_hold_wd", s_wdat, 32'hAABB_CCDD);
    chk("wr_hold_ad", s_addr, 32'h40);
    s_rdy = 1'b1;
    step();
    s_rdy = 1'b0;
    chk("wr_mrdy", 32'(m_rdy), 2);
    chk("wr_merr", 32'(m_err), 0);
    step();
    // timeout: master 1, slave silent, RESP after ACTIVE cycle 130
    m_vld = 2'b10; m_addr[1] = 32'h500; m_we[1] = 4'h0;
    step();
    m_vld = 2'b00;
    early = 1'b0;
    for (int k = 2; k <= 130; k++) begin
      step();
      early |= |m_rdy;
    end
    chk("to_early", 32'(early), 0);
    chk("to_svld130", 32'(s_vld), 1);
    step();
    chk("to_mrdy", 32'(m_rdy), 2);
    chk("to_merr", 32'(m_err), 2);
    chk("to_rdat", m_rdat, 32'hDEAD_BEEF);
    step();
    chk("to_done", 32'(m_rdy), 0);
    // race: s_rdy in ACTIVE cycle 130 is a normal completion
    m_vld = 2'b01;
    step();
    m_vld = 2'b00;
    repeat (129) step();
    s_rdy = 1'b1; s_rdat = 32'hCAFE_F00D;
    step();
    s_rdy = 1'b0;
    chk("rc_mrdy", 32'(m_rdy), 1);
    chk("rc_merr", 32'(m_err), 0);
    chk("rc_rdat", m_rdat, 32'hCAFE_F00D);
    step();
    // reset mid-ACTIVE: tie goes to master 1 now, after reset back to master 0
    m_vld = 2'b11;
    step();
    chk("rs_gnt", 32'(gnt), 2);
    #2 arst_n = 1'b0;
    #1;
    chk("rs_gnt0", 32'(gnt), 0);
    chk("rs_svld", 32'(s_vld), 0);
    chk("rs_saddr", s_addr, 0);
    chk("rs_rdat", m_rdat, 0);
    @(posedge clk);
    #2;
    chk("rs_mrdy", 32'(m_rdy), 0);
    arst_n = 1'b1;
    step();
    chk("rs_tie", 32'(gnt), 1);
    m_vld = 2'b00; s_rdy = 1'b1;
    step();
    s_rdy = 1'b0;
    chk("rs_fin", 32'(m_rdy), 1);
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
